// File: rtl/alut_apb_pkg13.sv
// ----------------------------------------------------------------------------
// alut_apb_pkg13
// Shared definitions for the ALUT APB master:
//   - request op encodings (write / read / poll / illegal)
//   - master FSM state type
//   - ALUT register addresses (kept in step with the ALUT defines)
//   - poll compare helper
// ----------------------------------------------------------------------------
package alut_apb_pkg13;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_GAP    = 2'd3
    } apb_state_t;

    localparam logic [6:0] AL_FRM_D_ADDR_L   = 7'h00;
    localparam logic [6:0] AL_FRM_D_ADDR_U   = 7'h04;
    localparam logic [6:0] AL_FRM_S_ADDR_L   = 7'h08;
    localparam logic [6:0] AL_FRM_S_ADDR_U   = 7'h0C;
    localparam logic [6:0] AL_S_PORT         = 7'h10;
    localparam logic [6:0] AL_D_PORT         = 7'h14;
    localparam logic [6:0] AL_MAC_ADDR_L     = 7'h18;
    localparam logic [6:0] AL_MAC_ADDR_U     = 7'h1C;
    localparam logic [6:0] AL_CUR_TIME       = 7'h20;
    localparam logic [6:0] AL_BB_AGE         = 7'h24;
    localparam logic [6:0] AL_DIV_CLK        = 7'h28;
    localparam logic [6:0] AL_STATUS         = 7'h2C;
    localparam logic [6:0] AL_COMMAND        = 7'h30;
    localparam logic [6:0] AL_LST_INV_ADDR_L = 7'h34;
    localparam logic [6:0] AL_LST_INV_ADDR_U = 7'h38;
    localparam logic [6:0] AL_LST_INV_PORT   = 7'h3C;

    // Only the bits selected by mask take part in the compare.
    function automatic logic poll_match(input logic [31:0] rdata,
                                        input logic [31:0] cmp,
                                        input logic [31:0] mask);
        return ((rdata ^ cmp) & mask) == 32'h0;
    endfunction

endpackage

// File: rtl/alut_poll_timer13.sv
// ----------------------------------------------------------------------------
// alut_poll_timer13
// Gap down-counter and poll read counter for the APB master's POLL op.
//   pclk13    : clock
//   p_reset13 : synchronous active-high reset
//   clear     : request accepted, restart the poll count
//   access    : an APB ACCESS cycle is in progress (one poll read)
//   gap_load  : entering GAP, load the idle-cycle counter
//   gap_run   : currently in GAP
//   gap_done  : last GAP cycle (terminal count reached)
//   last_read : the current read is the final one allowed before timeout
// ----------------------------------------------------------------------------
module alut_poll_timer13 #(
    parameter int POLL_GAP     = 4,
    parameter int POLL_TIMEOUT = 255
) (
    input  logic pclk13,
    input  logic p_reset13,
    input  logic clear,
    input  logic access,
    input  logic gap_load,
    input  logic gap_run,
    output logic gap_done,
    output logic last_read
);

    localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);
    localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);

    // GAP lasts POLL_GAP cycles: load N-1 and leave when the count hits zero.
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_TIMEOUT);

    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] poll_cnt;

    always_ff @(posedge pclk13) begin
        if (p_reset13) begin
            gap_cnt <= '0;
        end else if (gap_load) begin
            gap_cnt <= GAP_INIT;
        end else if (gap_run && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Counts completed reads; saturates instead of wrapping.
    always_ff @(posedge pclk13) begin
        if (p_reset13 || clear) begin
            poll_cnt <= '0;
        end else if (access && (poll_cnt != CNT_MAX)) begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    assign gap_done  = (gap_cnt == '0);
    // poll_cnt holds the number of reads finished before the current one.
    assign last_read = (poll_cnt >= CNT_LAST);

endmodule

// File: rtl/alut_apb_master13.sv
// ----------------------------------------------------------------------------
// alut_apb_master13
// APB initiator for the ALUT register bank. Takes one request at a time over
// valid/ready and turns it into a SETUP/ACCESS transfer; POLL repeats reads
// until a masked compare matches or the read budget runs out.
//   req_*      : request channel (op, addr, wdata/compare value, poll mask)
//   rsp_*      : one-cycle completion pulse with read data and error flag
//   psel13 .. prdata13 : APB initiator port (no pready)
//   busy13     : state is not IDLE
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a request, req_ready13 high
// ST_SETUP  | APB setup phase, psel high, penable low
// ST_ACCESS | APB access phase, prdata sampled at the end of this cycle
// ST_GAP    | poll back-off, psel low for POLL_GAP cycles
// ----------------------------------------------------------------------------
module alut_apb_master13
    import alut_apb_pkg13::*;
#(
    parameter int ADDR_W       = 7,
    parameter int POLL_GAP     = 4,
    parameter int POLL_TIMEOUT = 255
) (
    input  logic              pclk13,
    input  logic              p_reset13,
    input  logic              req_valid13,
    output logic              req_ready13,
    input  logic [1:0]        req_op13,
    input  logic [ADDR_W-1:0] req_addr13,
    input  logic [31:0]       req_wdata13,
    input  logic [31:0]       req_mask13,
    output logic              rsp_valid13,
    output logic [31:0]       rsp_rdata13,
    output logic              rsp_err13,
    output logic              psel13,
    output logic              penable13,
    output logic              pwrite13,
    output logic [ADDR_W-1:0] paddr13,
    output logic [31:0]       pwdata13,
    input  logic [31:0]       prdata13,
    output logic              busy13
);

    apb_state_t        state_q, state_nxt;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mask_q;

    logic accept;
    logic is_poll;
    logic match;
    logic gap_load;
    logic gap_done;
    logic last_read;

    assign req_ready13 = (state_q == ST_IDLE) & ~p_reset13;
    assign accept      = req_valid13 & req_ready13;
    assign is_poll     = (op_q == OP_POLL);
    assign match       = poll_match(prdata13, wdata_q, mask_q);

    alut_poll_timer13 #(
        .POLL_GAP     (POLL_GAP),
        .POLL_TIMEOUT (POLL_TIMEOUT)
    ) u_poll_timer (
        .pclk13    (pclk13),
        .p_reset13 (p_reset13),
        .clear     (accept),
        .access    (state_q == ST_ACCESS),
        .gap_load  (gap_load),
        .gap_run   (state_q == ST_GAP),
        .gap_done  (gap_done),
        .last_read (last_read)
    );

    always_ff @(posedge pclk13) begin
        if (p_reset13) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        gap_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && (req_op13 != OP_ILL)) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (is_poll && !match && !last_read) begin
                    if (POLL_GAP > 0) begin
                        state_nxt = ST_GAP;
                        gap_load  = 1'b1;
                    end else begin
                        state_nxt = ST_SETUP;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_nxt = ST_SETUP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk13) begin
        if (p_reset13) begin
            op_q    <= OP_WR;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else if (accept) begin
            op_q    <= req_op13;
            addr_q  <= req_addr13;
            wdata_q <= req_wdata13;
            mask_q  <= req_mask13;
        end
    end

    // APB and response outputs are registered from the next state so each
    // phase is visible in the cycle the FSM enters it.
    always_ff @(posedge pclk13) begin
        if (p_reset13) begin
            psel13      <= 1'b0;
            penable13   <= 1'b0;
            pwrite13    <= 1'b0;
            paddr13     <= '0;
            pwdata13    <= '0;
            rsp_valid13 <= 1'b0;
            rsp_rdata13 <= '0;
            rsp_err13   <= 1'b0;
            busy13      <= 1'b0;
        end else begin
            psel13      <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
            penable13   <= (state_nxt == ST_ACCESS);
            busy13      <= (state_nxt != ST_IDLE);
            rsp_valid13 <= 1'b0;

            if (state_nxt == ST_SETUP) begin
                // A repeat SETUP only happens for poll, so it is always a read.
                if (state_q == ST_IDLE) begin
                    paddr13  <= req_addr13;
                    pwrite13 <= (req_op13 == OP_WR);
                    pwdata13 <= (req_op13 == OP_WR) ? req_wdata13 : 32'h0;
                end else begin
                    paddr13  <= addr_q;
                    pwrite13 <= 1'b0;
                    pwdata13 <= 32'h0;
                end
            end else if (state_nxt != ST_ACCESS) begin
                pwrite13 <= 1'b0;
            end

            if ((state_q == ST_IDLE) && accept && (req_op13 == OP_ILL)) begin
                rsp_valid13 <= 1'b1;
                rsp_rdata13 <= 32'h0;
                rsp_err13   <= 1'b1;
            end else if ((state_q == ST_ACCESS) && (state_nxt == ST_IDLE)) begin
                rsp_valid13 <= 1'b1;
                rsp_rdata13 <= (op_q == OP_WR) ? 32'h0 : prdata13;
                rsp_err13   <= is_poll && !match;
            end
        end
    end

endmodule

// File: tb/tb_alut_apb_master13.sv
module tb_alut_apb_master13;
    import alut_apb_pkg13::*;

    logic        pclk13 = 1'b0;
    logic        p_reset13 = 1'b1;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic [1:0]  req_op13 = OP_WR;
    logic [6:0]  req_addr13 = '0;
    logic [31:0] req_wdata13 = '0;
    logic [31:0] req_mask13 = '0;

    logic        ready_a, rsp_valid_a, rsp_err_a, psel_a, penable_a, pwrite_a, busy_a;
    logic [31:0] rsp_rdata_a, pwdata_a;
    logic [6:0]  paddr_a;
    logic [31:0] prdata_a = '0;

    logic        ready_b, rsp_valid_b, rsp_err_b, psel_b, penable_b, pwrite_b, busy_b;
    logic [31:0] rsp_rdata_b, pwdata_b;
    logic [6:0]  paddr_b;
    logic [31:0] prdata_b = '0;

    int compared = 0;
    int mismatched = 0;

    always #5 pclk13 = ~pclk13;

    alut_apb_master13 #(.ADDR_W(7), .POLL_GAP(4), .POLL_TIMEOUT(255)) dut_a (
        .pclk13(pclk13), .p_reset13(p_reset13),
        .req_valid13(valid_a), .req_ready13(ready_a), .req_op13(req_op13),
        .req_addr13(req_addr13), .req_wdata13(req_wdata13), .req_mask13(req_mask13),
        .rsp_valid13(rsp_valid_a), .rsp_rdata13(rsp_rdata_a), .rsp_err13(rsp_err_a),
        .psel13(psel_a), .penable13(penable_a), .pwrite13(pwrite_a),
        .paddr13(paddr_a), .pwdata13(pwdata_a), .prdata13(prdata_a), .busy13(busy_a)
    );

    alut_apb_master13 #(.ADDR_W(7), .POLL_GAP(0), .POLL_TIMEOUT(3)) dut_b (
        .pclk13(pclk13), .p_reset13(p_reset13),
        .req_valid13(valid_b), .req_ready13(ready_b), .req_op13(req_op13),
        .req_addr13(req_addr13), .req_wdata13(req_wdata13), .req_mask13(req_mask13),
        .rsp_valid13(rsp_valid_b), .rsp_rdata13(rsp_rdata_b), .rsp_err13(rsp_err_b),
        .psel13(psel_b), .penable13(penable_b), .pwrite13(pwrite_b),
        .paddr13(paddr_b), .pwdata13(pwdata_b), .prdata13(prdata_b), .busy13(busy_b)
    );

    // Slave model A: register array, AL_STATUS returns 0x2 three times then 0x0.
    logic [31:0] mem [128] = '{default: 32'h0};
    int stat_reads = 0;
    int acc_a = 0, gap_a = 0, acc_b = 0, gap_b = 0;

    always @(posedge pclk13) begin
        if (psel_a && !penable_a && !pwrite_a) begin
            if (paddr_a == AL_STATUS) begin
                prdata_a   <= (stat_reads < 3) ? 32'h2 : 32'h0;
                stat_reads <= stat_reads + 1;
            end else begin
                prdata_a <= mem[paddr_a];
            end
        end
        if (psel_a && penable_a && pwrite_a) mem[paddr_a] <= pwdata_a;
        if (psel_a && penable_a) acc_a <= acc_a + 1;
        if (busy_a && !psel_a)   gap_a <= gap_a + 1;
    end

    // Slave model B: status stuck at 0x1.
    always @(posedge pclk13) begin
        if (psel_b && !penable_b && !pwrite_b) prdata_b <= 32'h1;
        if (psel_b && penable_b) acc_b <= acc_b + 1;
        if (busy_b && !psel_b)   gap_b <= gap_b + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk13);
        #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    // Called #1 after a rising edge; returns #1 after the response cycle.
    task automatic run_vec_a(input vec_t v, input string nm);
        logic [31:0] exp_pwdata;
        exp_pwdata  = (v.op == OP_WR) ? v.wdata : 32'h0;
        req_op13    = v.op;
        req_addr13  = v.addr;
        req_wdata13 = v.wdata;
        req_mask13  = 32'h0;
        valid_a     = 1'b1;
        chk({nm, " ready"}, 32'(ready_a), 32'd1);
        step();
        valid_a = 1'b0;
        if (v.op == OP_ILL) begin
            chk({nm, " ill psel"}, 32'(psel_a), 32'd0);
            chk({nm, " ill rsp_valid"}, 32'(rsp_valid_a), 32'd1);
            chk({nm, " ill err"}, 32'(rsp_err_a), 32'(v.exp_err));
            chk({nm, " ill rdata"}, rsp_rdata_a, v.exp_rdata);
            step();
            chk({nm, " ill psel2"}, 32'(psel_a), 32'd0);
            chk({nm, " ill rsp_valid2"}, 32'(rsp_valid_a), 32'd0);
        end else begin
            chk({nm, " setup psel"}, 32'(psel_a), 32'd1);
            chk({nm, " setup penable"}, 32'(penable_a), 32'd0);
            chk({nm, " setup pwrite"}, 32'(pwrite_a), 32'(v.op == OP_WR));
            chk({nm, " setup pwdata"}, pwdata_a, exp_pwdata);
            chk({nm, " setup paddr"}, 32'(paddr_a), 32'(v.addr));
            chk({nm, " setup busy"}, 32'(busy_a), 32'd1);
            step();
            chk({nm, " access psel"}, 32'(psel_a), 32'd1);
            chk({nm, " access penable"}, 32'(penable_a), 32'd1);
            chk({nm, " access rsp_valid"}, 32'(rsp_valid_a), 32'd0);
            step();
            chk({nm, " rsp_valid"}, 32'(rsp_valid_a), 32'd1);
            chk({nm, " rsp_rdata"}, rsp_rdata_a, v.exp_rdata);
            chk({nm, " rsp_err"}, 32'(rsp_err_a), 32'(v.exp_err));
            chk({nm, " idle psel"}, 32'(psel_a), 32'd0);
            chk({nm, " idle ready"}, 32'(ready_a), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, g0, n;
        bit seen;
        vec_t v;

        vecs[0] = '{OP_WR,  AL_DIV_CLK,    32'h0000_0055, 32'h0000_0000, 1'b0};
        vecs[1] = '{OP_RD,  AL_DIV_CLK,    32'h0000_0000, 32'h0000_0055, 1'b0};
        vecs[2] = '{OP_WR,  AL_BB_AGE,     32'h0000_1234, 32'h0000_0000, 1'b0};
        vecs[3] = '{OP_RD,  AL_BB_AGE,     32'hFFFF_FFFF, 32'h0000_1234, 1'b0};
        vecs[4] = '{OP_ILL, AL_COMMAND,    32'h1111_1111, 32'h0000_0000, 1'b1};
        vecs[5] = '{OP_WR,  AL_COMMAND,    32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[6] = '{OP_RD,  AL_COMMAND,    32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[7] = '{OP_RD,  AL_MAC_ADDR_L, 32'h0000_0000, 32'h0000_0000, 1'b0};

        // Reset values
        repeat (3) @(posedge pclk13);
        #1;
        chk("rst psel", 32'(psel_a), 32'd0);
        chk("rst penable", 32'(penable_a), 32'd0);
        chk("rst pwrite", 32'(pwrite_a), 32'd0);
        chk("rst paddr", 32'(paddr_a), 32'd0);
        chk("rst pwdata", pwdata_a, 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("rst rsp_rdata", rsp_rdata_a, 32'd0);
        chk("rst rsp_err", 32'(rsp_err_a), 32'd0);
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst ready", 32'(ready_a), 32'd0);
        p_reset13 = 1'b0;
        #1;
        chk("post-rst ready", 32'(ready_a), 32'd1);

        // Table-driven single transfers
        for (int i = 0; i < 8; i++) begin
            run_vec_a(vecs[i], $sformatf("vec%0d", i));
        end

        // Poll AL_STATUS with gap: 4 reads, 3 gaps of 4 idle cycles
        a0 = acc_a;
        g0 = gap_a;
        req_op13 = OP_POLL; req_addr13 = AL_STATUS; req_wdata13 = 32'h0; req_mask13 = 32'h2;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        chk("poll setup pwrite", 32'(pwrite_a), 32'd0);
        chk("poll setup paddr", 32'(paddr_a), 32'(AL_STATUS));
        seen = 1'b0;
        for (n = 0; n < 200; n++) begin
            if (rsp_valid_a) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("poll rsp seen", 32'(seen), 32'd1);
        chk("poll rdata", rsp_rdata_a, 32'h0);
        chk("poll err", 32'(rsp_err_a), 32'd0);
        chk("poll reads", 32'(acc_a - a0), 32'd4);
        chk("poll gap cycles", 32'(gap_a - g0), 32'd12);
        step();

        // Poll timeout on instance B (POLL_TIMEOUT=3, no gap)
        a0 = acc_b;
        g0 = gap_b;
        req_op13 = OP_POLL; req_addr13 = AL_STATUS; req_wdata13 = 32'h0; req_mask13 = 32'h1;
        valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        seen = 1'b0;
        for (n = 0; n < 50; n++) begin
            if (rsp_valid_b) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk("timeout rsp seen", 32'(seen), 32'd1);
        chk("timeout latency", 32'(n), 32'd6);
        chk("timeout rdata", rsp_rdata_b, 32'h1);
        chk("timeout err", 32'(rsp_err_b), 32'd1);
        chk("timeout reads", 32'(acc_b - a0), 32'd3);
        chk("timeout gap cycles", 32'(gap_b - g0), 32'd0);
        step();

        // Back-to-back writes to AL_BB_AGE with valid held
        req_op13 = OP_WR; req_addr13 = AL_BB_AGE; req_wdata13 = 32'hAA; req_mask13 = 32'h0;
        valid_a = 1'b1;
        step();
        req_wdata13 = 32'hBB;
        chk("b2b c1 pwdata", pwdata_a, 32'hAA);
        chk("b2b c1 ready", 32'(ready_a), 32'd0);
        step();
        step();
        chk("b2b c3 rsp_valid", 32'(rsp_valid_a), 32'd1);
        chk("b2b c3 ready", 32'(ready_a), 32'd1);
        step();
        valid_a = 1'b0;
        chk("b2b c4 psel", 32'(psel_a), 32'd1);
        chk("b2b c4 penable", 32'(penable_a), 32'd0);
        chk("b2b c4 pwdata", pwdata_a, 32'hBB);
        chk("b2b c4 rsp_valid", 32'(rsp_valid_a), 32'd0);
        step();
        chk("b2b c5 penable", 32'(penable_a), 32'd1);
        step();
        chk("b2b c6 rsp_valid", 32'(rsp_valid_a), 32'd1);
        chk("b2b c6 rdata", rsp_rdata_a, 32'h0);
        v = '{OP_RD, AL_BB_AGE, 32'h0, 32'hBB, 1'b0};
        run_vec_a(v, "b2b readback");

        // Reset during ACCESS of a read
        req_op13 = OP_RD; req_addr13 = AL_DIV_CLK; req_wdata13 = 32'h0;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step();
        chk("rstmid access penable", 32'(penable_a), 32'd1);
        p_reset13 = 1'b1;
        step();
        chk("rstmid psel", 32'(psel_a), 32'd0);
        chk("rstmid penable", 32'(penable_a), 32'd0);
        chk("rstmid rsp_valid", 32'(rsp_valid_a), 32'd0);
        chk("rstmid busy", 32'(busy_a), 32'd0);
        chk("rstmid ready", 32'(ready_a), 32'd0);
        p_reset13 = 1'b0;
        #1;
        chk("rstmid ready after", 32'(ready_a), 32'd1);
        v = '{OP_RD, AL_DIV_CLK, 32'h0, 32'h55, 1'b0};
        run_vec_a(v, "rstmid fresh read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alut_apb_master13.md
Name: alut_apb_master13

Overview:
- APB initiator that drives the ALUT register bank's APB slave port (psel/penable/pwrite/paddr/pwdata/prdata, no pready).
- Used by the on-chip config sequencer and by the test harness to program ALUT registers.
- Accepts one register request at a time over a valid/ready interface and converts it into a two-phase APB SETUP/ACCESS transfer.
- Also supports a POLL operation: repeatedly reads a register (typically AL_STATUS) until a masked compare matches or a timeout expires.

Parameters:
- ADDR_W, 7: APB address width.
- POLL_GAP, 4: idle cycles (psel low) between consecutive poll reads; 0 means none.
- POLL_TIMEOUT, 255: maximum number of poll reads before failing; must be at least 1.

Ports:
- pclk13  in  1  APB clock; the only clock.
- p_reset13  in  1  synchronous, active-high reset.
- req_valid13  in  1  request present.
- req_ready13  out  1  master can accept a request.
- req_op13  in  2  operation: 00 write, 01 read, 10 poll, 11 illegal.
- req_addr13  in  ADDR_W  register address.
- req_wdata13  in  32  write data, or poll compare value.
- req_mask13  in  32  poll compare mask; ignored for other ops.
- rsp_valid13  out  1  one-cycle completion pulse.
- rsp_rdata13  out  32  read data, or last poll read; 0 for writes.
- rsp_err13  out  1  poll timeout or illegal op.
- psel13  out  1  APB select.
- penable13  out  1  APB enable.
- pwrite13  out  1  APB direction.
- paddr13  out  ADDR_W  APB address.
- pwdata13  out  32  APB write data.
- prdata13  in  32  APB read data.
- busy13  out  1  high whenever the state is not IDLE.

Behaviour:
- Clocking and reset: one clock, pclk13. Reset p_reset13 is synchronous and active-high.
- Reset values: all outputs are 0, including req_ready13. The state is IDLE, and req_ready13 rises on the first cycle after p_reset13 deasserts.
- Output timing: all outputs are registered, except req_ready13 = (state==IDLE) & ~p_reset13.
- States: IDLE, SETUP, ACCESS, GAP.
- Accept: a request is accepted on a cycle where req_valid13 & req_ready13. op, addr, wdata and mask are latched, and the poll counter is cleared.
- Transitions:
  - IDLE -> SETUP on an accepted legal op.
  - SETUP -> ACCESS always.
  - ACCESS -> IDLE for write/read, or for poll on a match or timeout.
  - ACCESS -> GAP for poll with no match, count < POLL_TIMEOUT-1, and POLL_GAP > 0.
  - ACCESS -> SETUP for the same case when POLL_GAP == 0.
  - GAP -> SETUP after POLL_GAP cycles.
- SETUP phase: psel13=1, penable13=0, paddr13=addr, pwrite13=(op==write), pwdata13 = wdata for writes, 0 for read/poll.
- ACCESS phase: psel13=1, penable13=1, with address, data and direction held from SETUP.
- IDLE/GAP phase: psel13=0, penable13=0, pwrite13=0. paddr13 and pwdata13 hold their last values.
- Read data: the slave registers read data during SETUP, so prdata13 is valid during ACCESS. The master samples prdata13 on the clock edge that ends ACCESS.
- Timing: acceptance is at cycle 0, SETUP at 1, ACCESS at 2, and rsp_valid13 is high at cycle 3.
- Back-to-back: req_ready13 is high in cycle 3, so a new request can be accepted the same cycle as rsp_valid13. Peak throughput is one transfer per 3 cycles.
- Poll match: match = ((prdata13 ^ wdata) & mask) == 0. On a match, the response is err=0 with rdata = prdata13.
- Poll timeout: after POLL_TIMEOUT reads with no match, the response is err=1 with rdata = last prdata13.
- Poll counter: width $clog2(POLL_TIMEOUT+1). It increments at each ACCESS and never wraps.
- Poll side effects: every poll read is a full APB read. For AL_STATUS, each poll read therefore triggers the slave's clear-on-read of the reused flag.
- Illegal op 11: accepted, no APB activity, rsp_valid13=1 next cycle with err=1 and rdata=0.
- Reset mid-transfer: the transfer is aborted with no response. Next cycle psel13=penable13=0 and the state is IDLE.
- rsp_rdata13/rsp_err13: hold their values until the next response.

Decomposition:
- Package alut_apb_pkg13 holds:
  - op encoding constants (OP_WR, OP_RD, OP_POLL);
  - the state enum;
  - AL_* register address constants, shared with the ALUT defines.
- One natural sub-module, alut_poll_timer13, contains the gap down-counter and the poll-count/timeout logic. The FSM and APB drive stay in the top module.

Test Plan:
1. Write `AL_DIV_CLK`, wdata 0x55 -> cycle 1: psel=1, penable=0, pwrite=1, pwdata=0x55. Cycle 2: penable=1. Cycle 3: rsp_valid=1, rdata=0, err=0.
2. Read `AL_DIV_CLK` after test 1 -> cycle 1 pwrite=0, pwdata=0. Cycle 3: rsp_rdata=0x00000055, err=0.
3. Poll `AL_STATUS`, mask 0x2, value 0, slave returns 0x2 three times then 0x0, POLL_GAP=4 -> exactly 4 APB reads with 4 psel-low cycles between them, then rsp err=0, rdata=0.
4. POLL_TIMEOUT=3, status stuck at 0x1, mask 0x1, value 0 -> exactly 3 reads, then rsp err=1, rdata=0x1.
5. req_valid held with two writes (0xAA then 0xBB to `AL_BB_AGE`) -> second accepted in cycle 3 alongside rsp_valid, SETUP in cycle 4, second rsp in cycle 6. Also: op 11 -> rsp err=1 one cycle after accept, psel never high.
6. p_reset13 asserted during ACCESS of a read -> next cycle psel=penable=0, no rsp_valid. After deassert, req_ready=1 and a fresh read completes normally.
